// File: rtl/elevator_ctrl_n.sv
// Single-car elevator controller: latches floor calls, chooses travel
// direction with a sticky preference, and times floor travel and door dwell.
module elevator_ctrl_n #(
    parameter int N_FLOORS      = 4,
    parameter int TRAVEL_CYCLES = 50,
    parameter int DOOR_CYCLES   = 30
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_FLOORS-1:0] btn_stable_shot,
    output logic [2:0]          state,
    output logic [2:0]          cur_floor,
    output logic [N_FLOORS-1:0] pending,
    output logic                door_open,
    output logic                dir_up
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_UP   = 3'd1,
        S_DOWN = 3'd2,
        S_DOOR = 3'd3
    } state_t;

    localparam logic [15:0]         TRAVEL_LD = 16'(TRAVEL_CYCLES - 1);
    localparam logic [15:0]         DOOR_LD   = 16'(DOOR_CYCLES - 1);
    localparam logic [2:0]          TOP       = 3'(N_FLOORS - 1);
    localparam logic [N_FLOORS-1:0] ONE       = N_FLOORS'(1);

    state_t              r_state, w_state_nx;
    logic [2:0]          r_floor, w_floor_nx;
    logic [N_FLOORS-1:0] r_pending, w_pending_nx;
    logic [15:0]         r_timer, w_timer_nx;
    logic                r_dir_up, w_dir_nx;

    logic [N_FLOORS-1:0] w_cur_mask;
    logic [N_FLOORS-1:0] w_req_other;
    logic [N_FLOORS-1:0] w_step_mask;
    logic [N_FLOORS-1:0] w_all_req;
    logic [2:0]          w_step_floor;
    logic                w_any_above;
    logic                w_any_below;
    logic                w_call_here;
    logic                w_stop;
    logic                w_at_end;

    // One-hot of the current floor drives all above/below/here decisions.
    assign w_cur_mask   = ONE << r_floor;
    assign w_any_above  = |(r_pending & ~((w_cur_mask << 1) - ONE));
    assign w_any_below  = |(r_pending & (w_cur_mask - ONE));
    assign w_call_here  = |(btn_stable_shot & w_cur_mask);
    assign w_req_other  = btn_stable_shot & ~w_cur_mask;
    assign w_all_req    = r_pending | btn_stable_shot;
    assign w_step_mask  = (r_state == S_UP) ? (w_cur_mask << 1)
                                            : (w_cur_mask >> 1);
    assign w_step_floor = (r_state == S_UP) ? (r_floor + 3'd1)
                                            : (r_floor - 3'd1);
    assign w_stop       = |(w_all_req & w_step_mask);
    assign w_at_end     = (r_state == S_UP) ? (w_step_floor == TOP)
                                            : (w_step_floor == 3'd0);

    always_comb begin
        w_state_nx   = r_state;
        w_floor_nx   = r_floor;
        w_pending_nx = r_pending;
        w_timer_nx   = r_timer;
        w_dir_nx     = r_dir_up;
        case (r_state)
            S_IDLE: begin
                w_pending_nx = r_pending | w_req_other;
                if (w_call_here) begin
                    w_state_nx = S_DOOR;
                    w_timer_nx = DOOR_LD;
                end else if (w_any_above && (r_dir_up || !w_any_below)) begin
                    w_state_nx = S_UP;
                    w_dir_nx   = 1'b1;
                    w_timer_nx = TRAVEL_LD;
                end else if (w_any_below) begin
                    w_state_nx = S_DOWN;
                    w_dir_nx   = 1'b0;
                    w_timer_nx = TRAVEL_LD;
                end
            end
            S_UP, S_DOWN: begin
                w_pending_nx = w_all_req;
                if (r_timer == 16'd0) begin
                    w_floor_nx = w_step_floor;
                    if (w_stop) begin
                        w_state_nx   = S_DOOR;
                        w_pending_nx = w_all_req & ~w_step_mask;
                        w_timer_nx   = DOOR_LD;
                    end else if (w_at_end) begin
                        // Unreachable while a target remains; keeps the car in range.
                        w_state_nx = S_IDLE;
                    end else begin
                        w_timer_nx = TRAVEL_LD;
                    end
                end else begin
                    w_timer_nx = r_timer - 16'd1;
                end
            end
            S_DOOR: begin
                w_pending_nx = r_pending | w_req_other;
                if (w_call_here) begin
                    w_timer_nx = DOOR_LD;
                end else if (r_timer == 16'd0) begin
                    w_state_nx = S_IDLE;
                end else begin
                    w_timer_nx = r_timer - 16'd1;
                end
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_floor   <= 3'd0;
            r_pending <= '0;
            r_timer   <= 16'd0;
            r_dir_up  <= 1'b1;
        end else begin
            r_state   <= w_state_nx;
            r_floor   <= w_floor_nx;
            r_pending <= w_pending_nx;
            r_timer   <= w_timer_nx;
            r_dir_up  <= w_dir_nx;
        end
    end

    assign state     = r_state;
    assign cur_floor = r_floor;
    assign pending   = r_pending;
    assign door_open = (r_state == S_DOOR);
    assign dir_up    = r_dir_up;

endmodule

// File: doc/elevator_ctrl_n.md
ELEVATOR_CTRL_N -- requirements
Module: elevator_ctrl_n

Interface
REQ-001 Parameter N_FLOORS, default 4, number of floors served; legal range 2..8.
REQ-002 Parameter TRAVEL_CYCLES, default 50, clock cycles to move one floor; legal range 1..65535.
REQ-003 Parameter DOOR_CYCLES, default 30, clock cycles the door stays open; legal range 1..65535.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 btn_stable_shot  input  N_FLOORS  one-cycle request pulses, bit i = call to floor i; several bits may be high at once.
REQ-007 state  output  3  FSM state: 0 IDLE, 1 MOVE_UP, 2 MOVE_DOWN, 3 DOOR; other codes unused.
REQ-008 cur_floor  output  3  current floor, 0..N_FLOORS-1.
REQ-009 pending  output  N_FLOORS  latched, not-yet-served requests.
REQ-010 door_open  output  1  high exactly when state == DOOR.
REQ-011 dir_up  output  1  direction preference: 1 up, 0 down.

Function
REQ-012 Internal timer SHALL be 16 bits, loaded with TRAVEL_CYCLES-1 or DOOR_CYCLES-1, decremented once per cycle in MOVE_UP/MOVE_DOWN/DOOR.
REQ-013 Request bit i SHALL set pending[i] at the next edge, except the REQ-014 case; pending bits SHALL clear only on REQ-018 or reset.
REQ-014 Request for cur_floor while state is IDLE or DOOR SHALL not set pending; it SHALL enter DOOR from IDLE, or reload timer to DOOR_CYCLES-1 while in DOOR.
REQ-015 Request for cur_floor while moving SHALL set pending; it is served after a reversal.
REQ-016 IDLE, registered pending nonzero: any bit above cur_floor and (dir_up or no bit below) -> MOVE_UP, dir_up=1; otherwise any bit below -> MOVE_DOWN, dir_up=0; timer loaded TRAVEL_CYCLES-1; IDLE decisions SHALL use registered pending only (request-to-motion latency 2 cycles).
REQ-017 MOVE_UP/MOVE_DOWN with timer == 0: cur_floor SHALL step by +1/-1 at that edge; timer != 0: decrement only.
REQ-018 On the step edge, new floor F: if pending[F] or btn_stable_shot[F] is high that cycle -> DOOR, pending[F] cleared, timer = DOOR_CYCLES-1; else stay in same move state, timer reloaded TRAVEL_CYCLES-1.
REQ-019 cur_floor SHALL never leave 0..N_FLOORS-1; MOVE_UP is never entered or continued at floor N_FLOORS-1, nor MOVE_DOWN at floor 0.
REQ-020 DOOR with timer == 0 and no REQ-014 reload -> IDLE at next edge; dir_up unchanged.
REQ-021 Each floor traversal SHALL take exactly TRAVEL_CYCLES cycles in a move state; door dwell exactly DOOR_CYCLES cycles absent reloads.
REQ-022 Any illegal state code SHALL return to IDLE at next edge, other registers held.

Reset
REQ-023 rst high at an edge SHALL force state=IDLE, cur_floor=0, pending=0, timer=0, dir_up=1, door_open=0, overriding all other inputs including simultaneous requests.
REQ-024 Reset asserted mid-travel or mid-door SHALL take effect at that edge; no partial floor step is retained.

Verification (N_FLOORS=4, TRAVEL_CYCLES=4, DOOR_CYCLES=3)
REQ-025 After reset, pulse bit 2 at edge t -> pending=0100 after t, MOVE_UP after t+1, cur_floor=1 after t+5, 2 after t+9 with DOOR, pending=0000, IDLE after t+12.
REQ-026 IDLE at floor 0, pulse bit 0 -> DOOR next edge, pending stays 0000; repulse in DOOR extends dwell by reload to 2.
REQ-027 Moving up from 0 to 3, pulse bit 1 before floor-1 step and bit 0 during travel -> stops at 1, then 3, then reverses (dir_up=0) to 0.
REQ-028 At floor 1 idle with dir_up=1, pending 1000 and 0001 together -> MOVE_UP chosen first; with dir_up=0 -> MOVE_DOWN first.
REQ-029 Pulse for floor F on the exact edge cur_floor steps to F -> stops at F, pending[F] never left set.
REQ-030 rst asserted mid-MOVE_UP with a simultaneous request -> all outputs at reset values next cycle, pending=0000.
